// File: rtl/pushbutton_debounce_bank_if.sv
// Interface bundle for the pushbutton debounce bank: timebase enable, raw
// button pins and the per-channel debounced level and event pulses.
interface pushbutton_debounce_bank_if #(
    parameter int CHANNELS = 4
);
    logic                tick;
    logic [CHANNELS-1:0] button_in;
    logic [CHANNELS-1:0] DB_out;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] hold;

    // master drives the pins and timebase; slave is the debouncer itself
    modport master (
        output tick,
        output button_in,
        input  DB_out,
        input  rise,
        input  fall,
        input  hold
    );

    modport slave (
        input  tick,
        input  button_in,
        output DB_out,
        output rise,
        output fall,
        output hold
    );
endinterface

// File: rtl/pushbutton_debounce_bank.sv
// Bank of independent pushbutton debouncers: 2-FF synchroniser, exact-count
// stability filter, registered rise/fall pulses and long-press/auto-repeat pulse.
module pushbutton_debounce_bank #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 38000,
    parameter int REPEAT_CYCLES = 0,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic                          clk,
    input  logic                          n_reset,
    pushbutton_debounce_bank_if.slave     bus
);
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] H_SAT    = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] H_RELOAD = (REPEAT_CYCLES > 0) ?
                                         HW'(HOLD_CYCLES - REPEAT_CYCLES) :
                                         HW'(HOLD_CYCLES);
    localparam logic [CHANNELS-1:0] POL = {CHANNELS{(ACTIVE_LOW != 0)}};

    logic [CHANNELS-1:0] s1_q, s1_d;
    logic [CHANNELS-1:0] s2_q, s2_d;
    logic [CHANNELS-1:0] db_q, db_d;
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;
    logic [CHANNELS-1:0] hold_q, hold_d;
    logic [CW-1:0]       cnt_q  [CHANNELS];
    logic [CW-1:0]       cnt_d  [CHANNELS];
    logic [HW-1:0]       hcnt_q [CHANNELS];
    logic [HW-1:0]       hcnt_d [CHANNELS];

    always_comb begin
        s1_d   = bus.button_in ^ POL;
        s2_d   = s1_q;
        db_d   = db_q;
        rise_d = '0;
        fall_d = '0;
        hold_d = '0;
        cnt_d  = cnt_q;
        hcnt_d = hcnt_q;
        for (int i = 0; i < CHANNELS; i++) begin
            // any sample matching the committed level restarts the run, tick or not
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (bus.tick) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i]   = s2_q[i];
                    cnt_d[i]  = '0;
                    rise_d[i] = s2_q[i];
                    fall_d[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end

            // hcnt parks at H_SAT after a single pulse when repeat is disabled
            if (!db_q[i]) begin
                hcnt_d[i] = '0;
            end else if (bus.tick) begin
                if (hcnt_q[i] == H_LAST) begin
                    hold_d[i] = 1'b1;
                    hcnt_d[i] = H_RELOAD;
                end else if (hcnt_q[i] < H_SAT) begin
                    hcnt_d[i] = hcnt_q[i] + HW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            db_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
            hold_q <= '0;
            cnt_q  <= '{default: '0};
            hcnt_q <= '{default: '0};
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            hold_q <= hold_d;
            cnt_q  <= cnt_d;
            hcnt_q <= hcnt_d;
        end
    end

    assign bus.DB_out = db_q;
    assign bus.rise   = rise_q;
    assign bus.fall   = fall_q;
    assign bus.hold   = hold_q;
endmodule

// File: tb/tb_pushbutton_debounce_bank.sv
// Bench for pushbutton_debounce_bank: three instances (repeat, single-hold,
// active-low) checked every cycle against a tick-counting behavioural model.
module tb_pushbutton_debounce_bank;
    localparam int CH = 4;
    localparam int W  = 4 * CH;
    localparam int S  = 4;
    localparam int H  = 8;
    localparam int REP_M [3] = '{3, 0, 3};
    localparam int AL_M  [3] = '{0, 0, 1};

    logic clk;
    logic n_reset;
    logic tk;
    logic tick_div;
    logic [CH-1:0] bi_a;
    logic [CH-1:0] bi_c;
    int cyc_cnt;
    int n_checks;
    int n_fail;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    pushbutton_debounce_bank_if #(.CHANNELS(CH)) if_a ();
    pushbutton_debounce_bank_if #(.CHANNELS(CH)) if_b ();
    pushbutton_debounce_bank_if #(.CHANNELS(CH)) if_c ();

    assign if_a.tick = tk;
    assign if_b.tick = tk;
    assign if_c.tick = tk;
    assign if_a.button_in = bi_a;
    assign if_b.button_in = bi_a;
    assign if_c.button_in = bi_c;

    pushbutton_debounce_bank #(.CHANNELS(CH), .STABLE_CYCLES(S), .HOLD_CYCLES(H),
        .REPEAT_CYCLES(3), .ACTIVE_LOW(0)) dut_a (.clk(clk), .n_reset(n_reset), .bus(if_a));
    pushbutton_debounce_bank #(.CHANNELS(CH), .STABLE_CYCLES(S), .HOLD_CYCLES(H),
        .REPEAT_CYCLES(0), .ACTIVE_LOW(0)) dut_b (.clk(clk), .n_reset(n_reset), .bus(if_b));
    pushbutton_debounce_bank #(.CHANNELS(CH), .STABLE_CYCLES(S), .HOLD_CYCLES(H),
        .REPEAT_CYCLES(3), .ACTIVE_LOW(1)) dut_c (.clk(clk), .n_reset(n_reset), .bus(if_c));

    // ---------------- behavioural model ----------------
    // Per channel: count ticks of an uninterrupted disagreement run; commit
    // after S of them. Hold pulses at H ticks pressed, then every REP ticks.
    logic [W-1:0] exp_q_a[$];
    logic [W-1:0] exp_q_b[$];
    logic [W-1:0] exp_q_c[$];
    logic [CH-1:0] m_new [3];
    logic [CH-1:0] m_old [3];
    logic [CH-1:0] m_db  [3];
    int m_run   [3][CH];
    int m_press [3][CH];
    logic [CH-1:0] mp, ms2, mdb, mri, mfa, mho;

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int d = 0; d < 3; d++) begin
                m_new[d] = '0;
                m_old[d] = '0;
                m_db[d]  = '0;
                for (int c = 0; c < CH; c++) begin
                    m_run[d][c]   = 0;
                    m_press[d][c] = 0;
                end
            end
            exp_q_a.delete();
            exp_q_b.delete();
            exp_q_c.delete();
        end else begin
            for (int d = 0; d < 3; d++) begin
                mp  = (d == 2) ? bi_c : bi_a;
                if (AL_M[d] != 0) mp = ~mp;
                ms2 = m_old[d];
                mdb = m_db[d];
                mri = '0;
                mfa = '0;
                mho = '0;
                for (int c = 0; c < CH; c++) begin
                    if (m_db[d][c]) begin
                        if (tk) begin
                            m_press[d][c]++;
                            if (m_press[d][c] == H ||
                                (REP_M[d] > 0 && m_press[d][c] > H &&
                                 (m_press[d][c] - H) % REP_M[d] == 0))
                                mho[c] = 1'b1;
                        end
                    end else begin
                        m_press[d][c] = 0;
                    end
                    if (ms2[c] == m_db[d][c]) begin
                        m_run[d][c] = 0;
                    end else if (tk) begin
                        m_run[d][c]++;
                        if (m_run[d][c] == S) begin
                            m_run[d][c] = 0;
                            mdb[c] = ms2[c];
                            if (ms2[c]) mri[c] = 1'b1;
                            else        mfa[c] = 1'b1;
                        end
                    end
                end
                m_db[d]  = mdb;
                m_old[d] = m_new[d];
                m_new[d] = mp;
                case (d)
                    0:       exp_q_a.push_back({mdb, mri, mfa, mho});
                    1:       exp_q_b.push_back({mdb, mri, mfa, mho});
                    default: exp_q_c.push_back({mdb, mri, mfa, mho});
                endcase
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check_vec(input string name, input logic [W-1:0] act,
                             input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic compare_dut(input int d, input logic [W-1:0] act, input logic [CH-1:0] ri,
                               input logic [CH-1:0] fa);
        logic [W-1:0] e;
        check_vec("rise_fall_exclusive", {{(W-CH){1'b0}}, ri & fa}, '0);
        if (!n_reset) begin
            check_vec("reset_outputs", act, '0);
        end else begin
            case (d)
                0: if (exp_q_a.size() > 0) begin e = exp_q_a.pop_front(); check_vec("model_a", act, e); end
                1: if (exp_q_b.size() > 0) begin e = exp_q_b.pop_front(); check_vec("model_b", act, e); end
                default: if (exp_q_c.size() > 0) begin e = exp_q_c.pop_front(); check_vec("model_c", act, e); end
            endcase
        end
    endtask

    always @(negedge clk) begin
        compare_dut(0, {if_a.DB_out, if_a.rise, if_a.fall, if_a.hold}, if_a.rise, if_a.fall);
        compare_dut(1, {if_b.DB_out, if_b.rise, if_b.fall, if_b.hold}, if_b.rise, if_b.fall);
        compare_dut(2, {if_c.DB_out, if_c.rise, if_c.fall, if_c.hold}, if_c.rise, if_c.fall);
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc_cnt++;
            tk = tick_div ? (cyc_cnt % 4 == 0) : 1'b1;
        end
    endtask

    task automatic chk(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- directed stimulus ----------------
    int cnt_a, first_a, last_a, cnt_b, first_b;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc_cnt  = 0;
        tick_div = 1'b0;
        tk       = 1'b1;
        bi_a     = '0;
        bi_c     = '1;
        n_reset  = 1'b1;
        #1 n_reset = 1'b0;
        #1;
        chk("reset_db_a", if_a.DB_out, '0);
        chk("reset_hold_a", if_a.hold, '0);
        chk("reset_db_c", if_c.DB_out, '0);
        cyc(2);
        n_reset = 1'b1;
        cyc(4);
        chk("idle_active_low_db_c", if_c.DB_out, '0);

        // T1: press ch0, commit 6 edges later, release before the hold
        bi_a = 4'b0001;
        cyc(5);
        chk("t1_db_before", if_a.DB_out, 4'b0000);
        cyc(1);
        chk("t1_db_commit", if_a.DB_out, 4'b0001);
        chk("t1_rise", if_a.rise, 4'b0001);
        chk("t1_fall_none", if_a.fall, 4'b0000);
        cyc(1);
        chk("t1_rise_one_cycle", if_a.rise, 4'b0000);
        bi_a = 4'b0000;
        cyc(5);
        chk("t1_db_still_high", if_a.DB_out, 4'b0001);
        cyc(1);
        chk("t1_db_released", if_a.DB_out, 4'b0000);
        chk("t1_fall", if_a.fall, 4'b0001);
        cyc(1);
        chk("t1_no_pending_hold", if_a.hold, 4'b0000);
        cyc(3);

        // T2: 3-cycle glitch rejected, 4-cycle pulse accepted
        bi_a[1] = 1'b1;
        cyc(3);
        bi_a[1] = 1'b0;
        cyc(8);
        chk("t2_glitch_db", if_a.DB_out, 4'b0000);
        bi_a[1] = 1'b1;
        cyc(4);
        bi_a[1] = 1'b0;
        cyc(2);
        chk("t2_db_rise", if_a.DB_out, 4'b0010);
        chk("t2_rise", if_a.rise, 4'b0010);
        cyc(3);
        chk("t2_db_hold", if_a.DB_out, 4'b0010);
        cyc(1);
        chk("t2_db_fall", if_a.DB_out, 4'b0000);
        chk("t2_fall", if_a.fall, 4'b0010);
        cyc(4);

        // T3: long press on ch2, repeat (dut_a) vs single hold (dut_b)
        bi_a[2] = 1'b1;
        cyc(6);
        chk("t3_rise", if_a.rise, 4'b0100);
        cnt_a = 0; first_a = -1; last_a = -1; cnt_b = 0; first_b = -1;
        for (int k = 1; k <= 30; k++) begin
            cyc(1);
            if (if_a.hold[2]) begin
                cnt_a++;
                if (first_a < 0) first_a = k;
                last_a = k;
            end
            if (if_b.hold[2]) begin
                cnt_b++;
                first_b = k;
            end
        end
        chk_int("t3_hold_count_a", cnt_a, 8);
        chk_int("t3_hold_first_a", first_a, 8);
        chk_int("t3_hold_last_a", last_a, 29);
        chk_int("t3_hold_count_b", cnt_b, 1);
        chk_int("t3_hold_first_b", first_b, 8);
        bi_a[2] = 1'b0;
        cnt_a = 0; cnt_b = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc(1);
            if (if_a.hold[2]) cnt_a++;
            if (if_b.hold[2]) cnt_b++;
        end
        chk_int("t3_hold_after_release_a", cnt_a, 2);
        chk_int("t3_hold_after_release_b", cnt_b, 0);
        chk("t3_db_released", if_a.DB_out, 4'b0000);
        cyc(2);

        // T4: tick every 4th cycle on ch3, then a bounce in a tick-low gap
        tick_div = 1'b1;
        cyc(1);
        while (cyc_cnt % 4 != 0) cyc(1);
        bi_a[3] = 1'b1;
        cyc(16);
        chk("t4_db_before", if_a.DB_out, 4'b0000);
        cyc(1);
        chk("t4_db_commit", if_a.DB_out, 4'b1000);
        chk("t4_rise", if_a.rise, 4'b1000);
        while (cyc_cnt % 4 != 0) cyc(1);
        bi_a[3] = 1'b0;
        cyc(9);
        bi_a[3] = 1'b1;
        cyc(1);
        bi_a[3] = 1'b0;
        cyc(7);
        chk("t4_bounce_cleared", if_a.DB_out, 4'b1000);
        cyc(7);
        chk("t4_db_before_fall", if_a.DB_out, 4'b1000);
        cyc(1);
        chk("t4_db_fall", if_a.DB_out, 4'b0000);
        chk("t4_fall", if_a.fall, 4'b1000);
        tick_div = 1'b0;
        cyc(4);

        // T5: asynchronous reset during a hold pulse and a count in progress
        bi_a = 4'b0001;
        cyc(10);
        bi_a = 4'b0011;
        cyc(4);
        chk("t5_db_pre_reset", if_a.DB_out, 4'b0001);
        chk("t5_hold_pre_reset", if_a.hold, 4'b0001);
        #1 n_reset = 1'b0;
        #1;
        chk("t5_async_db", if_a.DB_out, 4'b0000);
        chk("t5_async_hold", if_a.hold, 4'b0000);
        chk("t5_async_db_b", if_b.DB_out, 4'b0000);
        cyc(2);
        n_reset = 1'b1;
        cyc(5);
        chk("t5_db_before", if_a.DB_out, 4'b0000);
        cyc(1);
        chk("t5_db_reassert", if_a.DB_out, 4'b0011);
        chk("t5_rise", if_a.rise, 4'b0011);
        chk("t5_no_fall", if_a.fall, 4'b0000);
        bi_a = 4'b0000;
        cyc(10);

        // T6: active-low bank, ch3 pressed while ch0-2 toggle every cycle
        bi_c[3] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bi_c[2:0] = ~bi_c[2:0];
            cyc(1);
        end
        chk("t6_db_c", if_c.DB_out, 4'b1000);
        chk("t6_rise_c", if_c.rise, 4'b1000);
        bi_c[3] = 1'b1;
        cyc(10);
        chk("t6_db_c_released", if_c.DB_out, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pushbutton_debounce_bank.md
Name: pushbutton_debounce_bank

Overview:
Multi-channel successor to the single-button debouncer. It takes CHANNELS raw pushbutton inputs and gives each one a 2-FF synchroniser, an exact-count stability filter and a debounced level output. It also produces registered rise and fall pulses and a long-press/auto-repeat pulse per channel. The block sits between the board pins and the processor's input and control logic, which consumes single-cycle event pulses instead of raw levels.

Parameters:
CHANNELS, 4, number of independent button channels (≥1)
STABLE_CYCLES, 1024, consecutive ticks the synchronised input must differ from DB_out before DB_out flips (≥2)
HOLD_CYCLES, 38000, ticks of continuous pressed state before the first hold pulse (≥2)
REPEAT_CYCLES, 0, ticks between subsequent hold pulses while still pressed; 0 = single hold pulse only (must be ≤HOLD_CYCLES)
ACTIVE_LOW, 0, 1 = raw input is low when pressed; the input is inverted before the synchroniser so all outputs mean "pressed"

Ports:
clk  in  1  system clock
n_reset  in  1  reset
tick  in  1  timebase enable; counters advance only on cycles where tick=1 (tie to 1 for clk-rate counting)
button_in  in  CHANNELS  raw asynchronous button inputs
DB_out  out  CHANNELS  debounced pressed level
rise  out  CHANNELS  1-cycle pulse on DB_out 0→1
fall  out  CHANNELS  1-cycle pulse on DB_out 1→0
hold  out  CHANNELS  1-cycle long-press / repeat pulse

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (n_reset=0, no clock needed): all sync FFs, counters, DB_out, rise, fall and hold go to 0 immediately. There are no spurious edges after release, because sync=0 matches DB_out=0.
- Per channel, fully independent. Let p = button_in^ACTIVE_LOW. Synchroniser: s1<=p, s2<=s1, both running every cycle regardless of tick.
- Stability counter cnt, width clog2(STABLE_CYCLES), applied per clock edge in priority order:
  - if s2==DB_out: cnt<=0 (unconditional, even when tick=0);
  - else if tick and cnt==STABLE_CYCLES-1: DB_out<=s2, cnt<=0;
  - else if tick: cnt<=cnt+1;
  - else cnt holds.
- Any bounce back to the current DB_out level clears the count, so only an uninterrupted run commits.
- Latency with tick=1: a button_in change at edge 0 flips DB_out at edge STABLE_CYCLES+2.
- rise/fall: registered and asserted in the same cycle DB_out changes, high for exactly 1 cycle. rise and fall are never both high.
- Hold counter hcnt, width clog2(HOLD_CYCLES+1):
  - DB_out==0: hcnt<=0 and hold stays 0.
  - DB_out==1 and tick:
    - if hcnt==HOLD_CYCLES-1: hold<=1; hcnt<=HOLD_CYCLES-REPEAT_CYCLES when REPEAT_CYCLES>0, else hcnt<=HOLD_CYCLES (saturated, no further pulses);
    - else if hcnt<HOLD_CYCLES: hcnt<=hcnt+1.
  - Timing: the first hold arrives HOLD_CYCLES ticks after the edge where DB_out rose, then every REPEAT_CYCLES ticks.
- hold is 0 on every cycle where it is not set by the rule above.
- Release mid-hold: hcnt clears on the first cycle DB_out==0. A pending hold pulse is not emitted.
- Reset mid-operation: all state is lost. A button still held after release needs a full STABLE_CYCLES+2 to reassert, then produces a rise pulse.
- No combinational path from inputs to outputs.

Test Plan:
1. STABLE=4, tick=1, button_in[0] 0→1 at edge 0 and held → DB_out[0]=1 from edge 6; rise[0]=1 only in cycle 6; fall=0 and other channels 0.
2. Glitches on ch1: high for 3 cycles then low → DB_out[1] stays 0 with no pulses. A later 4-cycle high pulse → DB_out[1] goes high (rise). After release, it falls 6 edges later (fall pulse).
3. HOLD=8, REPEAT=3, ch2 held 30 cycles after DB_out rises at edge E → hold[2] pulses at E+8, E+11, E+14, … and stops within 1 cycle of DB_out falling. With REPEAT=0 → a single pulse at E+8 only.
4. tick high every 4th cycle, STABLE=4 → DB_out flips 4 ticks (≈16 cycles) after sync. A bounce during a tick-low gap still clears cnt.
5. n_reset asserted asynchronously mid-count and mid-hold → all outputs 0 before the next clk edge. On release with the button held → rise after exactly STABLE+2 edges, and no fall pulse.
6. ACTIVE_LOW=1, all inputs idle at 1 → DB_out=0 with no pulses. Ch3 driven to 0 → DB_out[3]=1 with rise[3]. Ch0–2 are unaffected during simultaneous toggling.
